instruction_memory: RTL and testbench

Program store sitting on the far side of the processor's fetch interface. The processor presents `PCAddess` and samples `Instruction` on the same clock edge. This block holds the program in a DEPTH x 8 array and returns the addressed byte. It also accepts a byte-stream program load over a valid/ready port, and holds the processor in reset through `cpu_hold` until a load completes.

---
 rtl/instruction_memory.sv | 131 +++++++++++++
 tb/tb_instruction_memory.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// Program store behind the processor fetch port, loaded over a byte-stream valid/ready port.
// Optional `IMEM_RANGE_GUARD_EN: fetches at or beyond the loaded program length return NOP_WORD.
module instruction_memory #(
   parameter int         DEPTH    = 64,
   parameter logic [7:0] NOP_WORD = 8'hC0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] PCAddess,
   output logic [7:0] Instruction,
   input  logic       load_start,
   input  logic       load_valid,
   input  logic [7:0] load_data,
   input  logic       load_last,
   output logic       load_ready,
   output logic       cpu_hold,
   output logic [8:0] prog_len,
   output logic       load_overflow
);

   localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] LAST_PTR  = (AW + 1)'(DEPTH - 1);
   localparam logic [8:0]  DEPTH_LEN = 9'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_t;

   state_t          r_state;
   logic [AW:0]     r_wptr;
   logic [8:0]      r_progLen;
   logic            r_overflow;
   logic            r_cpuHold;
   logic            r_loadReady;
   logic [7:0]      r_mem [DEPTH];

   logic            w_write;
   logic [AW-1:0]   w_fetchIdx;

   // A load_start in LOAD wins over a same-cycle transfer, so that byte is dropped.
   assign w_write = (r_state == LOAD) && load_valid && !load_start;

   always_ff @(posedge clock) begin
      if (w_write) begin
         r_mem[r_wptr[AW-1:0]] <= load_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_wptr      <= '0;
         r_progLen   <= '0;
         r_overflow  <= 1'b0;
         r_cpuHold   <= 1'b1;
         r_loadReady <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (load_start) begin
                  r_state     <= LOAD;
                  r_wptr      <= '0;
                  r_overflow  <= 1'b0;
                  r_cpuHold   <= 1'b1;
                  r_loadReady <= 1'b1;
               end
            end
            LOAD: begin
               if (load_start) begin
                  r_wptr     <= '0;
                  r_overflow <= 1'b0;
               end else if (load_valid) begin
                  r_wptr <= r_wptr + 1'b1;
                  if (load_last) begin
                     r_state     <= RUN;
                     r_progLen   <= 9'(r_wptr) + 9'd1;
                     r_cpuHold   <= 1'b0;
                     r_loadReady <= 1'b0;
                  end else if (r_wptr == LAST_PTR) begin
                     // Array full with no end marker: run what fits and flag it.
                     r_state     <= RUN;
                     r_progLen   <= DEPTH_LEN;
                     r_overflow  <= 1'b1;
                     r_cpuHold   <= 1'b0;
                     r_loadReady <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (load_start) begin
                  r_state     <= LOAD;
                  r_wptr      <= '0;
                  r_overflow  <= 1'b0;
                  r_cpuHold   <= 1'b1;
                  r_loadReady <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_wptr      <= '0;
               r_cpuHold   <= 1'b1;
               r_loadReady <= 1'b0;
            end
         endcase
      end
   end

   assign w_fetchIdx = AW'({1'b0, PCAddess} % DEPTH_LEN);

   // Zero-latency fetch; NOP_WORD whenever the processor is held or nothing valid is addressed.
   always_comb begin
      Instruction = NOP_WORD;
      if (r_state == RUN) begin
`ifdef IMEM_RANGE_GUARD_EN
         if ({1'b0, PCAddess} < r_progLen) begin
            Instruction = r_mem[w_fetchIdx];
         end
`else
         Instruction = r_mem[w_fetchIdx];
`endif
      end
   end

   assign load_ready    = r_loadReady;
   assign cpu_hold      = r_cpuHold;
   assign prog_len      = r_progLen;
   assign load_overflow = r_overflow;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed scoreboard bench for instruction_memory (DEPTH=64); expectations follow IMEM_RANGE_GUARD_EN.
module tb_instruction_memory;

`ifdef IMEM_RANGE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   localparam logic [7:0] NOP = 8'hC0;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] PCAddess = '0;
   logic [7:0] Instruction;
   logic       load_start = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = '0;
   logic       load_last = 1'b0;
   logic       load_ready;
   logic       cpu_hold;
   logic [8:0] prog_len;
   logic       load_overflow;

   typedef struct {
      string      tag;
      logic [8:0] val;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] mdl [64];
   int         checks = 0;
   int         errors = 0;

   instruction_memory #(.DEPTH(64), .NOP_WORD(8'hC0)) dut (
      .clock(clock),
      .reset(reset),
      .PCAddess(PCAddess),
      .Instruction(Instruction),
      .load_start(load_start),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_last(load_last),
      .load_ready(load_ready),
      .cpu_hold(cpu_hold),
      .prog_len(prog_len),
      .load_overflow(load_overflow)
   );

   always #5 clock = ~clock;

   // Inputs change on the falling edge; outputs are looked at on the next falling edge.
   task automatic applyStimulus(input logic st, input logic vld, input logic [7:0] dat, input logic lst);
      load_start = st;
      load_valid = vld;
      load_data  = dat;
      load_last  = lst;
      @(negedge clock);
   endtask

   task automatic expectVal(input string tag, input logic [8:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sbq.push_back(e);
   endtask

   task automatic checkOutput(input logic [8:0] observed);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed %h", observed);
      end else begin
         e = sbq.pop_front();
         assert (observed === e.val) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", e.tag, observed, e.val);
         end
      end
   endtask

   task automatic expectStatus(input logic hold, input logic rdy, input logic [8:0] len, input logic ovf);
      expectVal("cpu_hold", 9'(hold));
      expectVal("load_ready", 9'(rdy));
      expectVal("prog_len", len);
      expectVal("load_overflow", 9'(ovf));
   endtask

   task automatic checkStatus();
      checkOutput(9'(cpu_hold));
      checkOutput(9'(load_ready));
      checkOutput(prog_len);
      checkOutput(9'(load_overflow));
   endtask

   task automatic readAt(input logic [7:0] addr, input logic [7:0] exp);
      expectVal($sformatf("fetch_%0d", addr), 9'(exp));
      PCAddess = addr;
      #1;
      checkOutput(9'(Instruction));
   endtask

   initial begin
      @(negedge clock);
      applyStimulus(0, 0, 8'h00, 0);
      applyStimulus(0, 0, 8'h00, 0);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'h00, 0);
      expectStatus(1, 0, 9'd0, 0);
      checkStatus();
      readAt(8'd0, NOP);

      // Three-byte program on consecutive cycles.
      expectStatus(1, 1, 9'd0, 0);
      applyStimulus(1, 0, 8'h00, 0);
      checkStatus();
      readAt(8'd1, NOP);
      mdl[0] = 8'h11; mdl[1] = 8'h22; mdl[2] = 8'h33;
      applyStimulus(0, 1, 8'h11, 0);
      expectStatus(1, 1, 9'd0, 0);
      applyStimulus(0, 1, 8'h22, 0);
      checkStatus();
      expectStatus(0, 0, 9'd3, 0);
      applyStimulus(0, 1, 8'h33, 1);
      checkStatus();
      readAt(8'd1, 8'h22);
      readAt(8'd0, 8'h11);
      readAt(8'd2, 8'h33);

      // Bytes offered while running must not be written.
      expectStatus(0, 0, 9'd3, 0);
      applyStimulus(0, 1, 8'h99, 1);
      checkStatus();
      readAt(8'd0, 8'h11);

      // Short reload leaves older bytes behind.
      applyStimulus(1, 0, 8'h00, 0);
      mdl[0] = 8'hAA;
      expectStatus(0, 0, 9'd1, 0);
      applyStimulus(0, 1, 8'hAA, 1);
      checkStatus();
      readAt(8'd0, 8'hAA);
      readAt(8'd2, GUARD ? NOP : mdl[2]);

      // Same three bytes with load_valid toggling; idle cycles carry junk.
      applyStimulus(1, 0, 8'h00, 0);
      mdl[0] = 8'h11;
      applyStimulus(0, 1, 8'h11, 0);
      expectStatus(1, 1, 9'd1, 0);
      applyStimulus(0, 0, 8'hFF, 1);
      checkStatus();
      applyStimulus(0, 1, 8'h22, 0);
      expectStatus(1, 1, 9'd1, 0);
      applyStimulus(0, 0, 8'hFF, 1);
      checkStatus();
      expectStatus(0, 0, 9'd3, 0);
      applyStimulus(0, 1, 8'h33, 1);
      checkStatus();
      readAt(8'd0, 8'h11);
      readAt(8'd1, 8'h22);
      readAt(8'd2, 8'h33);

      // Fill all 64 bytes without an end marker.
      applyStimulus(1, 0, 8'h00, 0);
      for (int i = 0; i < 63; i++) begin
         mdl[i] = 8'(i) ^ 8'h5A;
         applyStimulus(0, 1, mdl[i], 0);
      end
      expectStatus(1, 1, 9'd3, 0);
      checkStatus();
      mdl[63] = 8'd63 ^ 8'h5A;
      expectStatus(0, 0, 9'd64, 1);
      applyStimulus(0, 1, mdl[63], 0);
      checkStatus();
      readAt(8'd63, mdl[63]);
      readAt(8'd64, GUARD ? NOP : mdl[0]);
      readAt(8'd200, GUARD ? NOP : mdl[8]);

      // Accepted start clears the overflow flag.
      expectStatus(1, 1, 9'd64, 0);
      applyStimulus(1, 0, 8'h00, 0);
      checkStatus();

      // Restart mid-load; the byte offered with the restart is dropped.
      mdl[0] = 8'h44;
      applyStimulus(0, 1, 8'h44, 0);
      applyStimulus(1, 1, 8'hEE, 0);
      mdl[0] = 8'h55;
      expectStatus(0, 0, 9'd1, 0);
      applyStimulus(0, 1, 8'h55, 1);
      checkStatus();
      readAt(8'd0, 8'h55);
      readAt(8'd1, GUARD ? NOP : mdl[1]);

      // Reset in the middle of a load.
      applyStimulus(1, 0, 8'h00, 0);
      mdl[0] = 8'h66; mdl[1] = 8'h67;
      applyStimulus(0, 1, 8'h66, 0);
      applyStimulus(0, 1, 8'h67, 0);
      reset = 1'b0;
      expectStatus(1, 0, 9'd0, 0);
      applyStimulus(0, 0, 8'h00, 0);
      checkStatus();
      readAt(8'd0, NOP);
      reset = 1'b1;
      applyStimulus(0, 0, 8'h00, 0);
      applyStimulus(1, 0, 8'h00, 0);
      mdl[0] = 8'h77;
      expectStatus(0, 0, 9'd1, 0);
      applyStimulus(0, 1, 8'h77, 1);
      checkStatus();
      readAt(8'd0, 8'h77);
      readAt(8'd1, GUARD ? NOP : mdl[1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
